apb_arbiter: RTL and testbench

APB_ARBITER -- requirements
Module: apb_arbiter

---
 rtl/apb_arbiter_if.sv | 38 +++
 rtl/apb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_apb_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_arbiter_if.sv
// Requester-side request/response bundle plus the APB completer bus for apb_arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface apb_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*32-1:0]   req_addr;
    logic [NREQ-1:0]      req_write;
    logic [NREQ*32-1:0]   req_wdata;
    logic [NREQ-1:0]      req_ack;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;

    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [31:0]          paddr;
    logic [31:0]          pwdata;
    logic [3:0]           pstrb;
    logic [2:0]           pprot;
    logic [31:0]          prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata,
        output req_ack, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata,
        input  req_ack, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_arbiter.sv
// Round-robin arbiter of NREQ requesters onto one APB completer; grant to ack is 3 cycles with zero waits.
// Requests are held until acked; pready stalls ACCESS up to TIMEOUT cycles, out-of-range addresses error in 1 cycle.
module apb_arbiter #(
    parameter int          NREQ    = 2,
    parameter logic [31:0] BASE    = 32'h0001_0100,
    parameter logic [31:0] LIMIT   = 32'h0001_011C,
    parameter int          TIMEOUT = 16
) (
    input  logic          apb_clk,
    input  logic          rst,
    apb_arbiter_if.master bus
);
    localparam int GW = (NREQ > 2) ? 2 : 1;
    localparam int CW = GW + 1;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            write_q, write_d;
    logic            psel_q, psel_d;
    logic            penable_q, penable_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [7:0]      tmo_q, tmo_d;

    logic            pick_vld;
    logic [GW-1:0]   pick_idx;
    logic [CW-1:0]   cand;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic            sel_write;
    logic            in_range;

    // Walk from the farthest candidate to the nearest so the requester just after
    // last_q is written last and therefore wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = CW'(last_q) + CW'(i);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (bus.req_valid[cand[GW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == GW'(i)) begin
                sel_addr  = bus.req_addr[32*i +: 32];
                sel_wdata = bus.req_wdata[32*i +: 32];
                sel_write = bus.req_write[i];
            end
        end
    end

    assign in_range = (sel_addr >= BASE) && (sel_addr <= LIMIT);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        tmo_d   = '0;
        rdata_d = '0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    write_d = sel_write;
                    if (in_range) begin
                        state_d = SETUP;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    state_d = DONE;
                    err_d   = bus.pslverr;
                    rdata_d = (write_q || bus.pslverr) ? 32'h0 : bus.prdata;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                last_d  = grant_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        psel_d    = (state_d == SETUP) || (state_d == ACCESS);
        penable_d = (state_d == ACCESS);
        for (int i = 0; i < NREQ; i++) begin
            ack_d[i] = (state_d == DONE) && (grant_d == GW'(i));
        end
    end

    always_ff @(posedge apb_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= GW'(NREQ - 1);
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            ack_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = write_q;
    assign bus.paddr     = addr_q;
    assign bus.pwdata    = wdata_q;
    assign bus.pstrb     = 4'hF;
    assign bus.pprot     = 3'b010;
    assign bus.req_ack   = ack_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    a_penable_needs_psel: assert property (@(posedge apb_clk) disable iff (rst) penable_q |-> psel_q);
    a_ack_onehot:         assert property (@(posedge apb_clk) disable iff (rst) $onehot0(ack_q));
endmodule

// File: tb/tb_apb_arbiter.sv
// Scoreboard bench for apb_arbiter: expected responses are queued at request time and
// popped on each req_ack, alongside an APB completer model with programmable waits/errors.
module tb_apb_arbiter;
    localparam int          NREQ    = 2;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] BASE    = 32'h0001_0100;
    localparam logic [31:0] LIMIT   = 32'h0001_011C;

    logic apb_clk = 1'b0;
    logic rst     = 1'b1;
    int   cyc     = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   grant_cyc = 0;

    int          cfg_ws    = 0;
    logic        cfg_hang  = 1'b0;
    logic        cfg_err   = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;
    int          ws_cnt    = 0;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        wr;
        logic        err;
        int          pcyc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    apb_arbiter_if #(.NREQ(NREQ)) bus ();

    apb_arbiter #(
        .NREQ    (NREQ),
        .BASE    (BASE),
        .LIMIT   (LIMIT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .apb_clk (apb_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 apb_clk = ~apb_clk;
    always @(posedge apb_clk) cyc <= cyc + 1;

    // Completer model; prdata/pslverr carry junk until pready so only the ready beat may be captured.
    always @(negedge apb_clk) begin
        if (bus.psel && bus.penable) begin
            if (!cfg_hang && ws_cnt == cfg_ws) begin
                bus.pready  = 1'b1;
                bus.prdata  = cfg_rdata;
                bus.pslverr = cfg_err;
            end else begin
                bus.pready  = 1'b0;
                bus.prdata  = 32'hDEAD_BEEF;
                bus.pslverr = 1'b1;
                ws_cnt      = ws_cnt + 1;
            end
        end else begin
            bus.pready  = 1'b0;
            bus.prdata  = 32'hDEAD_BEEF;
            bus.pslverr = 1'b0;
            ws_cnt      = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        exp_t e;
        logic inr;
        inr     = (addr >= BASE) && (addr <= LIMIT);
        e.idx   = idx;
        e.addr  = addr;
        e.wr    = wr;
        e.wdata = wdata;
        if (!inr) begin
            e.err = 1'b1; e.rdata = 32'h0; e.pcyc = 0; e.lat = 1;
        end else if (cfg_hang) begin
            e.err = 1'b1; e.rdata = 32'h0; e.pcyc = 1 + TIMEOUT; e.lat = 2 + TIMEOUT;
        end else begin
            e.err   = cfg_err;
            e.rdata = (wr || cfg_err) ? 32'h0 : cfg_rdata;
            e.pcyc  = 2 + cfg_ws;
            e.lat   = 3 + cfg_ws;
        end
        sb.push_back(e);
    endtask

    task automatic drive_req(input int idx, input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        bus.req_addr[32*idx +: 32]  = addr;
        bus.req_wdata[32*idx +: 32] = wdata;
        bus.req_write[idx]          = wr;
        bus.req_valid[idx]          = 1'b1;
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_psel"},    32'(bus.psel),      32'h0);
        chk({pfx, "_penable"}, 32'(bus.penable),   32'h0);
        chk({pfx, "_ack"},     32'(bus.req_ack),   32'h0);
        chk({pfx, "_err"},     32'(bus.rsp_err),   32'h0);
        chk({pfx, "_rdata"},   bus.rsp_rdata,      32'h0);
        chk({pfx, "_paddr"},   bus.paddr,          32'h0);
        chk({pfx, "_pwdata"},  bus.pwdata,         32'h0);
        chk({pfx, "_pwrite"},  32'(bus.pwrite),    32'h0);
    endtask

    // Follows one transfer to its ack, then checks the ack lasted a single cycle.
    task automatic wait_ack(input logic drop);
        exp_t        e;
        logic [31:0] a0, d0;
        int          pc;
        logic        seen;
        seen = 1'b0; pc = 0; a0 = '0; d0 = '0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge apb_clk);
            if (bus.psel) begin
                pc++;
                if (!bus.penable) begin
                    a0 = bus.paddr;
                    d0 = bus.pwdata;
                    if (sb.size() > 0) begin
                        chk("setup_paddr",  bus.paddr,        sb[0].addr);
                        chk("setup_pwrite", 32'(bus.pwrite),  32'(sb[0].wr));
                        chk("setup_pwdata", bus.pwdata,       sb[0].wdata);
                    end
                end else begin
                    chk("access_paddr_hold",  bus.paddr,  a0);
                    chk("access_pwdata_hold", bus.pwdata, d0);
                end
            end
            if (bus.req_ack != '0) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'(bus.req_ack), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_vector",  32'(bus.req_ack), 32'h1 << e.idx);
                    chk("rsp_rdata",   bus.rsp_rdata,    e.rdata);
                    chk("rsp_err",     32'(bus.rsp_err), 32'(e.err));
                    chk("psel_cycles", 32'(pc),          32'(e.pcyc));
                    chk("latency",     32'(cyc - grant_cyc + 1), 32'(e.lat));
                    if (drop) bus.req_valid[e.idx] = 1'b0;
                end
            end
        end
        chk("ack_seen", 32'(seen), 32'h1);
        if (seen) begin
            @(negedge apb_clk);
            chk("ack_one_cycle", 32'(bus.req_ack), 32'h0);
        end
    endtask

    task automatic single(input int idx, input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        push_exp(idx, addr, wr, wdata);
        drive_req(idx, addr, wr, wdata);
        grant_cyc = cyc + 1;
        wait_ack(1'b1);
    endtask

    initial begin
        logic        seen;
        int          idx_seq[4];
        logic [31:0] addr_of[2];
        logic        wr_of[2];
        logic [31:0] wd_of[2];

        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_write = '0;
        bus.req_wdata = '0;
        repeat (3) @(negedge apb_clk);
        chk_quiet("reset");
        chk("reset_pstrb", 32'(bus.pstrb), 32'hF);
        chk("reset_pprot", 32'(bus.pprot), 32'h2);
        rst = 1'b0;
        @(negedge apb_clk);

        // Both requesters held across four transfers: rotation must be 0,1,0,1.
        cfg_ws = 0; cfg_err = 1'b0; cfg_hang = 1'b0; cfg_rdata = 32'h1234_5678;
        addr_of[0] = 32'h0001_0108; wr_of[0] = 1'b0; wd_of[0] = 32'h0000_0000;
        addr_of[1] = 32'h0001_0110; wr_of[1] = 1'b1; wd_of[1] = 32'h5555_AAAA;
        idx_seq[0] = 0; idx_seq[1] = 1; idx_seq[2] = 0; idx_seq[3] = 1;
        for (int k = 0; k < 4; k++) push_exp(idx_seq[k], addr_of[idx_seq[k]], wr_of[idx_seq[k]], wd_of[idx_seq[k]]);
        drive_req(0, addr_of[0], wr_of[0], wd_of[0]);
        drive_req(1, addr_of[1], wr_of[1], wd_of[1]);
        grant_cyc = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(k >= 2);
            grant_cyc = cyc + 1;
        end

        cfg_rdata = 32'hA5A5_0001;
        single(0, 32'h0001_0104, 1'b0, 32'h0);

        single(1, 32'h0002_0000, 1'b0, 32'h0);
        single(0, 32'h0001_00FC, 1'b1, 32'h1111_2222);
        single(1, 32'h0001_0120, 1'b0, 32'h0);

        cfg_ws = 1; cfg_rdata = 32'h0BAD_F00D;
        single(1, BASE, 1'b0, 32'h0);

        cfg_hang = 1'b1;
        single(0, 32'h0001_0110, 1'b0, 32'h0);

        cfg_hang = 1'b0; cfg_ws = 3; cfg_err = 1'b1;
        single(0, LIMIT, 1'b1, 32'h0F0F_F0F0);

        // Requester 1 is next in rotation; strand it in ACCESS and reset.
        cfg_ws = 0; cfg_err = 1'b0; cfg_hang = 1'b1; cfg_rdata = 32'h7777_0007;
        drive_req(0, 32'h0001_0108, 1'b0, 32'h0);
        drive_req(1, 32'h0001_0114, 1'b1, 32'hCAFE_0002);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge apb_clk);
            if (bus.psel && bus.penable) seen = 1'b1;
        end
        chk("reach_access", 32'(seen), 32'h1);
        chk("stranded_paddr", bus.paddr, 32'h0001_0114);
        rst = 1'b1;
        @(negedge apb_clk);
        chk_quiet("midrst");
        rst = 1'b0;
        cfg_hang = 1'b0;
        push_exp(0, 32'h0001_0108, 1'b0, 32'h0);
        push_exp(1, 32'h0001_0114, 1'b1, 32'hCAFE_0002);
        grant_cyc = cyc + 1;
        wait_ack(1'b1);
        grant_cyc = cyc + 1;
        wait_ack(1'b1);

        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
